// File: rtl/scan_seq8_pkg.sv
// Shared types and constants for the scan_seq8 keyboard-style line scanner.
package scan_seq8_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDwell
    } state_t;

    typedef logic [2:0] line_t;

    // Decoder enable levels with both halves switched off
    localparam logic Ea1Idle  = 1'b0;
    localparam logic Ea2nIdle = 1'b1;
    localparam logic Eb1nIdle = 1'b1;
    localparam logic Eb2nIdle = 1'b1;

    localparam line_t LastLine = 3'd7;

endpackage

// File: rtl/scan_seq8_timer.sv
// Loadable down-counter; done is high on the final cycle of a loaded interval.
module scan_seq8_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/scan_seq8.sv
// Eight-line scanner driving a dual 2-to-4 decoder with break-before-make timing.
// Define SCAN_SEQ8_DEBOUNCE_EN to publish a frame only when it repeats the previous raw frame.
module scan_seq8
    import scan_seq8_pkg::*;
#(
    parameter int unsigned BLANK = 1,
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    output logic       busy,
    output logic       a0,
    output logic       a1,
    output logic       ea1,
    output logic       ea2_n,
    output logic       eb1_n,
    output logic       eb2_n,
    input  logic       sense_n,
    output logic [7:0] scan_data,
    output logic       scan_valid
);

    localparam int unsigned MaxLen = (BLANK > DWELL) ? BLANK : DWELL;
    localparam int unsigned TW     = $clog2(MaxLen + 1);

    state_t      state_q, state_d;
    line_t       line_q, line_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  scan_data_q;
    logic        scan_valid_q;
    logic        tmr_load;
    logic [TW-1:0] tmr_val;
    logic        tmr_done;
    logic        frame_end;
`ifdef SCAN_SEQ8_DEBOUNCE_EN
    logic [7:0]  prev_raw_q;
`endif

    scan_seq8_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        shadow_d  = shadow_q;
        tmr_load  = 1'b0;
        tmr_val   = TW'(BLANK - 1);
        frame_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StBlank;
                    line_d   = '0;
                    tmr_load = 1'b1;
                end
            end
            StBlank: begin
                if (tmr_done) begin
                    state_d  = StDwell;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(DWELL - 1);
                end
            end
            StDwell: begin
                if (tmr_done) begin
                    shadow_d[line_q] = ~sense_n;
                    tmr_load = 1'b1;
                    line_d   = line_q + 3'd1;
                    if (line_q == LastLine) begin
                        frame_end = 1'b1;
                        state_d   = cont ? StBlank : StIdle;
                    end else begin
                        state_d = StBlank;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            line_q       <= '0;
            shadow_q     <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
`ifdef SCAN_SEQ8_DEBOUNCE_EN
            prev_raw_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            shadow_q     <= shadow_d;
            scan_valid_q <= 1'b0;
            if (frame_end) begin
`ifdef SCAN_SEQ8_DEBOUNCE_EN
                if (shadow_d == prev_raw_q) begin
                    scan_data_q  <= shadow_d;
                    scan_valid_q <= 1'b1;
                end
                prev_raw_q <= shadow_d;
`else
                scan_data_q  <= shadow_d;
                scan_valid_q <= 1'b1;
`endif
            end
        end
    end

    // Address only moves on BLANK entry, so enables decode straight from registered state
    logic dwell_a, dwell_b;
    assign dwell_a = (state_q == StDwell) && !line_q[2];
    assign dwell_b = (state_q == StDwell) &&  line_q[2];

    assign ea1   = dwell_a ? 1'b1 : Ea1Idle;
    assign ea2_n = dwell_a ? 1'b0 : Ea2nIdle;
    assign eb1_n = dwell_b ? 1'b0 : Eb1nIdle;
    assign eb2_n = dwell_b ? 1'b0 : Eb2nIdle;

    assign a1         = line_q[1];
    assign a0         = line_q[0];
    assign busy       = (state_q != StIdle);
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;

endmodule
